// File: rtl/cap_n16r4p2_pkg.sv
// Shared constants and lookahead helpers for the 16-bit two-level carry-lookahead adder.
package cap_n16r4p2_pkg;

  localparam int CAP_N    = 16;
  localparam int GRP_W    = 4;
  localparam int GRP_N    = CAP_N / GRP_W;
  localparam int RES_W    = CAP_N + 1;
  localparam int CAP_LVLS = 2;

  // Generate term of a 4-wide lookahead span; the same form serves bit level and group level.
  function automatic logic cla_gen4(input logic [3:0] g, input logic [3:0] p);
    cla_gen4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Propagate term of a 4-wide lookahead span.
  function automatic logic cla_prop4(input logic [3:0] p);
    cla_prop4 = &p;
  endfunction

endpackage

// File: rtl/cap_cla4_group.sv
// One 4-bit carry-lookahead group: local carries, sum bits, and group generate/propagate.
module cap_cla4_group
  import cap_n16r4p2_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       gg,
  output logic       gp
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [3:0] c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // In-group carries are all derived directly from ci, never rippled bit to bit.
  always_comb begin
    c_s    = 4'b0000;
    c_s[0] = ci;
    c_s[1] = g_s[0] | (p_s[0] & ci);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & ci);
  end

  assign sum = p_s ^ c_s;
  assign gg  = cla_gen4(g_s, p_s);
  assign gp  = cla_prop4(p_s);

endmodule

// File: rtl/cap_n16r4p2.sv
// 16-bit zero-latency adder: four 4-bit lookahead groups joined by a second lookahead level.
module cap_n16r4p2
  import cap_n16r4p2_pkg::*;
#(
  parameter int N = 16,
  parameter int R = 4,
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N:0]   res
);

  // The structure below is hand-built for exactly one geometry.
  if (N != CAP_N || R != GRP_W || P != CAP_LVLS) begin : g_param_chk
    $error("cap_n16r4p2 supports only N=16, R=4, P=2");
  end

  logic [GRP_N-1:0] gg_s;
  logic [GRP_N-1:0] gp_s;
  logic [GRP_N:0]   gc_s;
  logic [N-1:0]     sum_s;

  for (genvar i = 0; i < GRP_N; i++) begin : g_grp
    cap_cla4_group u_grp (
      .a   (in1[i*GRP_W +: GRP_W]),
      .b   (in2[i*GRP_W +: GRP_W]),
      .ci  (gc_s[i]),
      .sum (sum_s[i*GRP_W +: GRP_W]),
      .gg  (gg_s[i]),
      .gp  (gp_s[i])
    );
  end

  // Second-level lookahead: group carry-ins c4, c8, c12 and carry-out c16, with carry-in 0.
  always_comb begin
    gc_s    = 5'b00000;
    gc_s[0] = 1'b0;
    gc_s[1] = gg_s[0];
    gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]);
    gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0]);
    gc_s[4] = cla_gen4(gg_s, gp_s);
  end

  assign res = {gc_s[GRP_N], sum_s};

  // Clock and reset exist only for interface compatibility with the pipelined variants.
  logic unused_ctl_s;
  assign unused_ctl_s = &{1'b0, clk, rstn};

endmodule

// File: tb/tb_cap_n16r4p2.sv
// Self-checking bench for cap_n16r4p2: directed table, random vs arithmetic model, ramp, reset toggle.
module tb_cap_n16r4p2;

  logic        clk;
  logic        rstn;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [16:0] res;

  int vectors;
  int miscompares;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [8];

  cap_n16r4p2 dut (
    .clk  (clk),
    .rstn (rstn),
    .in1  (in1),
    .in2  (in2),
    .res  (res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [16:0] exp);
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: in1=%h in2=%h res=%h expected %h", name, $time, in1, in2, res, exp);
    end
  endtask

  // Apply on the falling edge, sample just after the following rising edge.
  task automatic apply(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ra;
    int rb;
    logic [15:0] x;
    logic [15:0] y;
    logic [16:0] model;

    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    in1         = 16'h0000;
    in2         = 16'h0000;

    tbl[0] = '{16'h0000, 16'h0000, 17'h00000, "zero"};
    tbl[1] = '{16'hFFFF, 16'h0001, 17'h10000, "full_ripple"};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE, "max_max"};
    tbl[3] = '{16'h0FFF, 16'h0001, 17'h01000, "carry_c12"};
    tbl[4] = '{16'h00F0, 16'h0010, 17'h00100, "carry_c8"};
    tbl[5] = '{16'h000F, 16'h0001, 17'h00010, "carry_c4"};
    tbl[6] = '{16'h8000, 16'h8000, 17'h10000, "msb_only"};
    tbl[7] = '{16'hAAAA, 16'h5555, 17'h0FFFF, "all_prop"};

    // Output must follow the inputs while reset is held.
    apply(16'h0000, 16'h0000);
    check("reset_zero", 17'h00000);
    apply(16'h1111, 16'h2222);
    check("reset_tracks", 17'h03333);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].a, tbl[i].b);
      check(tbl[i].name, tbl[i].exp);
    end

    for (int i = 0; i < 2000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 8 == 0) y = ~x;
      model = 17'(int'(x) + int'(y));
      apply(x, y);
      check("random", model);
    end

    // Ramp from reset release: in1 steps by 10, in2 by 20, so the sum steps by 30.
    @(negedge clk);
    rstn = 1'b0;
    in1  = 16'h0000;
    in2  = 16'h0000;
    @(negedge clk);
    rstn = 1'b1;
    ra   = 0;
    rb   = 0;
    for (int k = 1; k <= 60; k++) begin
      ra += 10;
      rb += 20;
      apply(16'(ra), 16'(rb));
      check("ramp", 17'(30 * k));
    end

    // Reset toggling mid-stream must not disturb the sum.
    apply(16'h1234, 16'h4321);
    check("hold_pre", 17'h05555);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rstn = ~rstn;
      @(posedge clk);
      #1;
      check("rstn_toggle", 17'h05555);
      @(negedge clk);
      #1;
      check("rstn_toggle_neg", 17'h05555);
    end
    rstn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cap_n16r4p2.md
CAP_N16R4P2 -- requirements
Module: cap_n16r4p2

Interface
REQ-001 Parameter N, default 16: operand width in bits, fixed for this block.
REQ-002 Parameter R, default 4: carry-lookahead group size (radix-4, i.e. 4 bits per group), fixed.
REQ-003 Parameter P, default 2: number of carry-lookahead levels (group level plus block level), fixed.
REQ-004 clk  input  1: clock; reset rstn, synchronous, active-low; clock clk.
REQ-005 rstn  input  1: synchronous active-low reset.
REQ-006 in1  input  16: unsigned operand A.
REQ-007 in2  input  16: unsigned operand B.
REQ-008 res  output  17: unsigned sum; res[16] is the carry-out.

Function
REQ-009 res SHALL equal in1 + in2 exactly, zero-extended to 17 bits, for all 2^32 input pairs.
- No approximation, no saturation, no wrap; carry-out always lands in res[16].
REQ-010 Latency SHALL be zero cycles: res is a purely combinational function of the current in1/in2.
- Inputs change on the falling edge and must be checked on the next rising edge.
REQ-011 res SHALL settle within one half clock period of the fastest target clock.
- The bench clock period is 10 ns.
REQ-012 Carry generation SHALL be carry-lookahead.
- Per-bit generate g = a&b and propagate p = a^b.
- Four 4-bit groups, each producing group G/P.
- Second-level lookahead computes group carry-ins c4, c8, c12 and c16 from the group G/P values, with carry-in = 0.
REQ-013 Sum bit i SHALL be p[i] ^ c[i]; res[16] SHALL be c16.
REQ-014 There is no handshake and no valid signal; every input combination is always accepted.

Reset
REQ-015 clk and rstn SHALL NOT affect res; res tracks in1 + in2 whether rstn is 0 or 1.
- This includes the cycle in which rstn is asserted or deasserted.
REQ-016 The block SHALL contain no architectural state.
- clk and rstn are retained for interface compatibility with the pipelined variants of the family.
- Any internal register SHALL reset to 0 synchronously on rstn = 0 and SHALL NOT drive res.

Structure
REQ-017 The shared package SHALL hold N = 16, the group size 4, the group count 4, and the result width N + 1.
REQ-018 One sub-module, cap_cla4_group, SHALL be used, instantiated 4 times.
- Inputs: 4-bit a, 4-bit b, 1-bit carry-in.
- Outputs: 4-bit sum, group G, group P.
REQ-019 The top level SHALL contain the second-level lookahead unit and the output concatenation only.

Verification
REQ-020 in1 = 0x0000, in2 = 0x0000 -> res = 0x00000 on the same cycle.
REQ-021 in1 = 0xFFFF, in2 = 0x0001 -> res = 0x10000 (full ripple through all 4 groups).
REQ-022 in1 = 0xFFFF, in2 = 0xFFFF -> res = 0x1FFFE.
REQ-023 in1 = 0x0FFF, in2 = 0x0001 -> res = 0x01000; in1 = 0x00F0, in2 = 0x0010 -> res = 0x00100.
- Exercises group-boundary carries c12 and c8.
REQ-024 Ramp test:
- From reset release, on each falling edge: in1 += 10, in2 += 20.
- Every rising edge: res == in1 + in2, e.g. in1 = 50, in2 = 100 -> res = 150.
- Any mismatch is reported with time.
REQ-025 Toggle rstn mid-ramp with in1 = 0x1234, in2 = 0x4321 -> res stays 0x05555 throughout.
